// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port, word-addressed RAM with byte-lane selects between the
// instruction-fetch port (read-only) and the data port (load / store with byte and
// halfword stores). One grant per cycle; read data comes back one cycle after grant.
// Optional feature macro: ROUND_ROBIN_EN
//   defined     -> on contention the port that was not granted last wins
//   not defined -> data port has fixed priority over fetch
module mem_port_arbiter #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // instruction-fetch port
  input  logic                 if_req_i,
  input  logic [31:0]          if_addr_i,
  output logic                 if_ready_o,
  output logic                 if_rvalid_o,
  output logic [31:0]          if_rdata_o,
  // data port
  input  logic                 d_req_i,
  input  logic                 d_we_i,
  input  logic                 d_sh_i,
  input  logic                 d_sb_i,
  input  logic [31:0]          d_addr_i,
  input  logic [31:0]          d_wdata_i,
  output logic                 d_ready_o,
  output logic                 d_rvalid_o,
  output logic [31:0]          d_rdata_o,
  output logic                 d_err_o,
  // RAM side
  output logic                 ram_en_o,
  output logic                 ram_we_o,
  output logic [ADDR_BITS-1:0] ram_addr_o,
  output logic [DATA_BITS-1:0] ram_din_o,
  output logic [3:0]           ram_sel_o,
  input  logic [DATA_BITS-1:0] ram_dout_i
);

  // Owner of the read currently in flight (its data arrives next cycle)
  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_IF   = 2'd1,
    PEND_D    = 2'd2
  } pend_e;

  localparam logic LAST_IF = 1'b0;
  localparam logic LAST_D  = 1'b1;

  pend_e       pend_q, pend_d;
  logic        last_q, last_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        d_is_half;
  logic        d_is_byte;
  logic        d_misaligned;
  logic        d_valid;
  logic        if_valid;
  logic        d_reject;
  logic        grant_d;
  logic        grant_if;
  logic [31:0] steer_din;
  logic [3:0]  steer_sel;
  logic [31:0] ram_word;

  assign ram_word = 32'(ram_dout_i);

  // Decode the data access size; {sh,sb}=11 behaves as a full word
  always_comb begin
    d_is_half    = 1'b0;
    d_is_byte    = 1'b0;
    d_misaligned = 1'b0;
    d_is_half    = d_sh_i && !d_sb_i;
    d_is_byte    = d_sb_i && !d_sh_i;
    if (d_is_half) begin
      d_misaligned = d_addr_i[0];
    end else if (d_is_byte) begin
      d_misaligned = 1'b0;
    end else begin
      d_misaligned = (d_addr_i[1:0] != 2'b00);
    end
  end

  // Pick at most one port per cycle; misaligned data requests never compete
  always_comb begin
    grant_d  = 1'b0;
    grant_if = 1'b0;
    d_valid  = d_req_i && !d_misaligned && !rst_i;
    if_valid = if_req_i && !rst_i;
    d_reject = d_req_i && d_misaligned && !rst_i;
`ifdef ROUND_ROBIN_EN
    if (d_valid && if_valid) begin
      if (last_q == LAST_IF) begin
        grant_d = 1'b1;
      end else begin
        grant_if = 1'b1;
      end
    end else begin
      grant_d  = d_valid;
      grant_if = if_valid;
    end
`else
    grant_d  = d_valid;
    grant_if = if_valid && !d_valid;
`endif
  end

  // Place right-aligned store data on the byte lanes selected by the low address bits
  always_comb begin
    steer_din = d_wdata_i;
    steer_sel = 4'hF;
    case ({d_sh_i, d_sb_i})
      2'b01: begin
        steer_din = d_wdata_i << {d_addr_i[1:0], 3'b000};
        steer_sel = 4'b0001 << d_addr_i[1:0];
      end
      2'b10: begin
        steer_din = d_wdata_i << {d_addr_i[1], 4'b0000};
        steer_sel = 4'b0011 << {d_addr_i[1], 1'b0};
      end
      default: begin
        steer_din = d_wdata_i;
        steer_sel = 4'hF;
      end
    endcase
  end

  // Drive the RAM from whichever port won; everything is zero when idle
  always_comb begin
    ram_en_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_din_o  = '0;
    ram_sel_o  = 4'h0;
    if (grant_d) begin
      ram_en_o   = 1'b1;
      ram_we_o   = d_we_i;
      ram_addr_o = ADDR_BITS'(d_addr_i >> 2);
      if (d_we_i) begin
        ram_din_o = DATA_BITS'(steer_din);
        ram_sel_o = steer_sel;
      end else begin
        ram_sel_o = 4'hF;
      end
    end else if (grant_if) begin
      ram_en_o   = 1'b1;
      ram_addr_o = ADDR_BITS'(if_addr_i >> 2);
      ram_sel_o  = 4'hF;
    end
  end

  // Handshakes: a misaligned data request is accepted and flagged without touching RAM
  always_comb begin
    if_ready_o = grant_if;
    d_ready_o  = grant_d || d_reject;
    d_err_o    = d_reject;
  end

  // Return read data to the owner of the in-flight read; otherwise hold the last word
  always_comb begin
    if_rvalid_o = (pend_q == PEND_IF) && !rst_i;
    d_rvalid_o  = (pend_q == PEND_D) && !rst_i;
    if_rdata_d  = if_rvalid_o ? ram_word : if_rdata_q;
    d_rdata_d   = d_rvalid_o ? ram_word : d_rdata_q;
    if_rdata_o  = if_rdata_d;
    d_rdata_o   = d_rdata_d;
  end

  // Next owner of the read in flight and the most recently granted port
  always_comb begin
    pend_d = PEND_NONE;
    last_d = last_q;
    if (grant_d) begin
      last_d = LAST_D;
      if (!d_we_i) begin
        pend_d = PEND_D;
      end
    end else if (grant_if) begin
      last_d = LAST_IF;
      pend_d = PEND_IF;
    end
  end

  // State registers; reset drops any read in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q     <= PEND_NONE;
      last_q     <= LAST_IF;
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
    end else begin
      pend_q     <= pend_d;
      last_q     <= last_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

endmodule
